fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of the control unit: owns the PC, issues word reads to instruction memory over a valid/ready request channel, and buffers returned instructions in a 2-entry queue. Each buffered instruction is handed to decode with its PC and pre-extracted 5-bit opcode (instr[6:2]), which drives the control unit's `op` input. Branch/jump redirects from execute flush the queue and discard any in-flight response.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset
- `XLEN`, 32, address/instruction width

- `clk` in 1, rising-edge clock
- `rst_n` in 1, asynchronous active-low reset
- `imem_req_valid` out 1, fetch request valid
- `imem_req_ready` in 1, memory accepts request
- `imem_req_addr` out XLEN, word-aligned fetch address
- `imem_rsp_valid` in 1, response data valid (in order, ≥1 cycle after accept)
- `imem_rsp_data` in XLEN, instruction word
- `redirect_valid` in 1, taken branch/jump from execute
- `redirect_pc` in XLEN, new PC (bits [1:0] ignored, forced 0)
- `id_valid` out 1, instruction available to decode
- `id_ready` in 1, decode consumes head entry
- `id_instr` out XLEN, head instruction
- `id_pc` out XLEN, PC of head instruction
- `id_opcode` out 5, id_instr[6:2], to control unit `op`

## Operation
- FSM states: REQ, WAIT, DROP; reset state REQ. At most one outstanding request.
- REQ: `imem_req_valid` = (count < 2) and not `redirect_valid`; `imem_req_addr` = pc. On handshake: latch req_pc = pc, pc += 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), go WAIT.
- WAIT: on `imem_rsp_valid`, push {req_pc, data} into buffer, go REQ. No new request issued in the response cycle.
- DROP: next `imem_rsp_valid` is discarded (not pushed), go REQ.
- Buffer: 2-entry FIFO; pop when `id_valid && id_ready`; push and pop in same cycle allowed at any count; push at count 2 cannot occur (REQ gating guarantees space).
- Redirect (highest priority, any state): buffer flushed (count 0), pc = {redirect_pc[31:2],2'b00}. Next state: DROP if in WAIT without `imem_rsp_valid` that cycle, else REQ (response arriving in the redirect cycle is dropped). Request suppressed in the redirect cycle, so no handshake conflicts. Pop in redirect cycle is ignored.
- `id_valid` = count != 0; `id_instr`/`id_pc`/`id_opcode` from head entry.

## Timing
- Reset (async assert, sync release): pc = RESET_PC, state REQ, count 0, buffer entries 0; `imem_req_valid` 0, `imem_req_addr` RESET_PC, `id_valid` 0, `id_instr` 0, `id_pc` 0, `id_opcode` 0.
- First request asserted first cycle after `rst_n` deasserts.
- Response in cycle M → `id_valid` high cycle M+1.
- Redirect in cycle N → request with addr = redirect_pc at N+1 (REQ) or after dropped response (DROP).
- Peak throughput: one instruction per 2 cycles with 1-cycle memory latency.
- Reset mid-WAIT: outstanding response after reset release must not occur (memory shares reset).

## Structure
- Shared package/defines: `OPCODE_*` constants, fetch FSM state encoding, RESET_PC default, XLEN.
- Sub-module `fetch_buffer`: 2-entry FIFO, 64-bit entries {pc, instr}, push/pop/flush, count output.

## Test plan
- Reset release, memory ready, 1-cycle latency returning 32'h0000_0013 → requests at 0x0, 0x4, 0x8; id_pc 0x0, id_opcode 5'b00100.
- `id_ready` held 0 → after 2 buffered instructions `imem_req_valid` stays 0; raise `id_ready` → fetch resumes at 0x8.
- Redirect to 0x0000_0103 while WAIT on 0x4 → response for 0x4 dropped, next request addr 0x0000_0100, id_pc 0x100.
- Redirect in same cycle as response → response dropped, state REQ, request at redirect_pc next cycle.
- `imem_req_ready` low for 3 cycles → addr stable at 0x0, pc not incremented.
- RESET_PC = 32'hFFFF_FFFC → second request addr 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int          XLEN         = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  // RV32I major opcodes as seen on instr[6:2] (the control unit's op input).
  localparam logic [4:0] OPCODE_LOAD   = 5'b00000;
  localparam logic [4:0] OPCODE_OP_IMM = 5'b00100;
  localparam logic [4:0] OPCODE_AUIPC  = 5'b00101;
  localparam logic [4:0] OPCODE_STORE  = 5'b01000;
  localparam logic [4:0] OPCODE_OP     = 5'b01100;
  localparam logic [4:0] OPCODE_LUI    = 5'b01101;
  localparam logic [4:0] OPCODE_BRANCH = 5'b11000;
  localparam logic [4:0] OPCODE_JALR   = 5'b11001;
  localparam logic [4:0] OPCODE_JAL    = 5'b11011;
  localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  // One buffered instruction with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Redirect targets are forced to word alignment.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return a & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus bundle: imem request/response, redirect, decode handoff.
interface fetch_unit_if #(parameter int XLEN = 32);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic [4:0]      id_opcode;

  // Fetch unit side.
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output id_valid, id_instr, id_pc, id_opcode,
    input  id_ready
  );

  // Memory / execute / decode side.
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  id_valid, id_instr, id_pc, id_opcode,
    output id_ready
  );
endinterface

// File: rtl/fetch_buffer.sv
// 2-entry FIFO of {pc, instr}; flush empties it without touching storage.
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  // Pointer/count update; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem requests, 2-deep buffer to decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            run;
  logic [1:0]      count;
  fetch_entry_t    head;
  logic            req_valid;
  logic            hs;
  logic            push;
  logic            pop;
  logic            redir;

  assign redir     = bus.redirect_valid;
  // run keeps the request low while reset is held and releases it one edge later.
  assign req_valid = run && (state == S_REQ) && (count != 2'd2) && !redir;
  assign hs        = req_valid && bus.imem_req_ready;
  assign push      = (state == S_WAIT) && bus.imem_rsp_valid && !redir;
  assign pop       = (count != 2'd0) && bus.id_ready && !redir;

  // Fetch FSM and PC; a redirect overrides everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      req_pc <= '0;
      run    <= 1'b0;
    end else begin
      run <= 1'b1;
      if (redir) begin
        pc <= align_pc(bus.redirect_pc);
        // A response still owed (WAIT or DROP, not arriving now) must be swallowed.
        state <= ((state != S_REQ) && !bus.imem_rsp_valid) ? S_DROP : S_REQ;
      end else begin
        case (state)
          S_REQ: if (hs) begin
            req_pc <= pc;
            pc     <= pc + PC_STEP;
            state  <= S_WAIT;
          end
          S_WAIT:  if (bus.imem_rsp_valid) state <= S_REQ;
          S_DROP:  if (bus.imem_rsp_valid) state <= S_REQ;
          default: state <= S_REQ;
        endcase
      end
    end
  end

  fetch_buffer u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .din   ('{pc: req_pc, instr: bus.imem_rsp_data}),
    .head  (head),
    .count (count)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.id_valid       = (count != 2'd0);
  assign bus.id_instr       = head.instr;
  assign bus.id_pc          = head.pc;
  assign bus.id_opcode      = head.instr[6:2];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle vector table plus reset/wrap sequences.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32)) bus ();
  fetch_unit_if #(.XLEN(32)) wbus ();

  fetch_unit u_dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(wbus.master));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          rdy, rv;
    logic [31:0] rdata;
    bit          redir;
    logic [31:0] rpc;
    bit          idr;
    bit          qv;
    logic [31:0] qaddr;
    bit          iv;
    logic [31:0] ipc, iinstr;
  } vec_t;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  function automatic vec_t v(bit rdy, bit rv, logic [31:0] rdata, bit redir, logic [31:0] rpc,
                             bit idr, bit qv, logic [31:0] qaddr, bit iv,
                             logic [31:0] ipc, logic [31:0] iinstr);
    vec_t r;
    r.rdy = rdy; r.rv = rv; r.rdata = rdata; r.redir = redir; r.rpc = rpc; r.idr = idr;
    r.qv = qv; r.qaddr = qaddr; r.iv = iv; r.ipc = ipc; r.iinstr = iinstr;
    return r;
  endfunction

  vec_t tbl [24];

  task automatic drive(input bit rdy, input bit rv, input logic [31:0] rdata,
                       input bit redir, input logic [31:0] rpc, input bit idr);
    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = rdata;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.id_ready       = idr;
  endtask

  initial begin
    // Instruction data = {addr[24:0], 7'h13}: all ADDI, opcode field 5'b00100.
    //            rdy rv rdata        rd rpc           idr | qv qaddr         iv ipc           instr
    tbl[0]  = v(H, L, 32'h0,       L, 32'h0,   L,  H, 32'h000, L, 32'h0,   32'h0);
    tbl[1]  = v(H, H, 32'h13,      L, 32'h0,   L,  L, 32'h004, L, 32'h0,   32'h0);
    tbl[2]  = v(H, L, 32'h0,       L, 32'h0,   H,  H, 32'h004, H, 32'h000, 32'h13);
    tbl[3]  = v(H, H, 32'h213,     L, 32'h0,   H,  L, 32'h008, L, 32'h0,   32'h0);
    tbl[4]  = v(H, L, 32'h0,       L, 32'h0,   L,  H, 32'h008, H, 32'h004, 32'h213);
    tbl[5]  = v(H, H, 32'h413,     L, 32'h0,   L,  L, 32'h00C, H, 32'h004, 32'h213);
    tbl[6]  = v(H, L, 32'h0,       L, 32'h0,   L,  L, 32'h00C, H, 32'h004, 32'h213);
    tbl[7]  = v(H, L, 32'h0,       L, 32'h0,   L,  L, 32'h00C, H, 32'h004, 32'h213);
    tbl[8]  = v(H, L, 32'h0,       L, 32'h0,   H,  L, 32'h00C, H, 32'h004, 32'h213);
    tbl[9]  = v(H, L, 32'h0,       L, 32'h0,   L,  H, 32'h00C, H, 32'h008, 32'h413);
    tbl[10] = v(L, L, 32'h0,       H, 32'h103, L,  L, 32'h010, H, 32'h008, 32'h413);
    tbl[11] = v(H, H, 32'h613,     L, 32'h0,   L,  L, 32'h100, L, 32'h0,   32'h0);
    tbl[12] = v(L, L, 32'h0,       L, 32'h0,   L,  H, 32'h100, L, 32'h0,   32'h0);
    tbl[13] = v(L, L, 32'h0,       L, 32'h0,   L,  H, 32'h100, L, 32'h0,   32'h0);
    tbl[14] = v(L, L, 32'h0,       L, 32'h0,   L,  H, 32'h100, L, 32'h0,   32'h0);
    tbl[15] = v(H, L, 32'h0,       L, 32'h0,   L,  H, 32'h100, L, 32'h0,   32'h0);
    tbl[16] = v(L, H, 32'h8013,    L, 32'h0,   H,  L, 32'h104, L, 32'h0,   32'h0);
    tbl[17] = v(H, L, 32'h0,       L, 32'h0,   L,  H, 32'h104, H, 32'h100, 32'h8013);
    tbl[18] = v(L, H, 32'h8213,    H, 32'h200, H,  L, 32'h108, H, 32'h100, 32'h8013);
    tbl[19] = v(H, L, 32'h0,       L, 32'h0,   L,  H, 32'h200, L, 32'h0,   32'h0);
    tbl[20] = v(L, H, 32'h10013,   L, 32'h0,   L,  L, 32'h204, L, 32'h0,   32'h0);
    tbl[21] = v(L, L, 32'h0,       L, 32'h0,   L,  H, 32'h204, H, 32'h200, 32'h10013);
    tbl[22] = v(H, L, 32'h0,       H, 32'h40,  L,  L, 32'h204, H, 32'h200, 32'h10013);
    tbl[23] = v(L, L, 32'h0,       L, 32'h0,   L,  H, 32'h040, L, 32'h0,   32'h0);

    drive(L, L, 32'h0, L, 32'h0, L);
    wbus.imem_req_ready = 1'b0;
    wbus.imem_rsp_valid = 1'b0;
    wbus.imem_rsp_data  = 32'h0;
    wbus.redirect_valid = 1'b0;
    wbus.redirect_pc    = 32'h0;
    wbus.id_ready       = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_req_addr",  bus.imem_req_addr, 32'h0);
    chk("rst_id_valid",  32'(bus.id_valid), 32'd0);
    chk("rst_id_instr",  bus.id_instr, 32'h0);
    chk("rst_id_pc",     bus.id_pc, 32'h0);
    chk("rst_id_opcode", 32'(bus.id_opcode), 32'd0);
    chk("rst_wrap_addr", wbus.imem_req_addr, 32'hFFFF_FFFC);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(tbl[i].rdy, tbl[i].rv, tbl[i].rdata, tbl[i].redir, tbl[i].rpc, tbl[i].idr);
      #1;
      chk($sformatf("row%0d_req_valid", i), 32'(bus.imem_req_valid), 32'(tbl[i].qv));
      chk($sformatf("row%0d_req_addr", i), bus.imem_req_addr, tbl[i].qaddr);
      chk($sformatf("row%0d_id_valid", i), 32'(bus.id_valid), 32'(tbl[i].iv));
      if (tbl[i].iv) begin
        chk($sformatf("row%0d_id_pc", i), bus.id_pc, tbl[i].ipc);
        chk($sformatf("row%0d_id_instr", i), bus.id_instr, tbl[i].iinstr);
        chk($sformatf("row%0d_id_opcode", i), 32'(bus.id_opcode), 32'(5'b00100));
      end
    end

    // Fetch 0x40, buffer it, then reset asynchronously mid-cycle.
    @(negedge clk); drive(H, L, 32'h0, L, 32'h0, L);
    @(negedge clk); drive(L, H, 32'h2013, L, 32'h0, L); #1;
    chk("mid_wait_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("mid_wait_addr", bus.imem_req_addr, 32'h44);
    @(negedge clk); drive(L, L, 32'h0, L, 32'h0, L); #1;
    chk("buf_id_pc", bus.id_pc, 32'h40);
    chk("buf_id_instr", bus.id_instr, 32'h2013);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("arst_req_addr",  bus.imem_req_addr, 32'h0);
    chk("arst_id_valid",  32'(bus.id_valid), 32'd0);
    chk("arst_id_pc",     bus.id_pc, 32'h0);
    chk("arst_id_instr",  bus.id_instr, 32'h0);
    chk("arst_id_opcode", 32'(bus.id_opcode), 32'd0);

    // Release and exercise the PC wrap on the second instance.
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wbus.imem_req_ready = 1'b1;
    #1;
    chk("rel_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("rel_req_addr", bus.imem_req_addr, 32'h0);
    chk("wrap_req_valid0", 32'(wbus.imem_req_valid), 32'd1);
    chk("wrap_req_addr0", wbus.imem_req_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    wbus.imem_req_ready = 1'b0;
    wbus.imem_rsp_valid = 1'b1;
    wbus.imem_rsp_data  = 32'h0000_0013;
    #1;
    chk("wrap_wait_valid", 32'(wbus.imem_req_valid), 32'd0);
    chk("wrap_req_addr1", wbus.imem_req_addr, 32'h0);
    @(negedge clk);
    wbus.imem_rsp_valid = 1'b0;
    #1;
    chk("wrap_req_valid1", 32'(wbus.imem_req_valid), 32'd1);
    chk("wrap_id_valid", 32'(wbus.id_valid), 32'd1);
    chk("wrap_id_pc", wbus.id_pc, 32'hFFFF_FFFC);
    chk("wrap_id_opcode", 32'(wbus.id_opcode), 32'(5'b00100));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
